odd_wb_merge: RTL and testbench

//  Write-back merge stage of the odd pipe: downstream of the permute unit and load/store unit.

---
 rtl/odd_wb_merge.sv | 116 +++++++++++
 tb/tb_odd_wb_merge.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/odd_wb_merge.sv
// Odd-pipe write-back merge: queues permute and load/store results in program order and presents
// one registered RF write per cycle. Define ODD_WB_FWD_EN to enable the pending-write lookup.
module odd_wb_merge #(
   parameter int DEPTH        = 8,
   parameter int STALL_MARGIN = 5
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [0:127] perm_rt,
   input  logic [0:6]   perm_rt_addr,
   input  logic         perm_reg_write,
   input  logic [0:127] ls_rt,
   input  logic [0:6]   ls_rt_addr,
   input  logic         ls_reg_write,
   input  logic         rf_ready,
   output logic         rf_wr_en,
   output logic [0:6]   rf_wr_addr,
   output logic [0:127] rf_wr_data,
   output logic         stall,
   output logic         overflow,
   input  logic [0:6]   fwd_addr,
   output logic         fwd_hit,
   output logic [0:127] fwd_data
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [0:127]  data_q [DEPTH];
   logic [0:6]    addr_q [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] ls_ptr;
   logic [CW-1:0] count;
   logic [CW-1:0] free_slots;
   logic          load;
   logic          deq;
   logic          perm_acc;
   logic          ls_acc;

   // Free space includes the slot released by a same-cycle dequeue; perm claims first (older).
   always_comb begin
      load       = !rf_wr_en || rf_ready;
      deq        = load && (count != '0);
      free_slots = CW'(DEPTH) - count + CW'(deq);
      perm_acc   = perm_reg_write && (free_slots != '0);
      ls_acc     = ls_reg_write && (free_slots > CW'(perm_acc));
      ls_ptr     = wr_ptr + PW'(perm_acc);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         overflow   <= 1'b0;
         rf_wr_en   <= 1'b0;
         rf_wr_addr <= '0;
         rf_wr_data <= '0;
      end else begin
         wr_ptr <= wr_ptr + PW'(perm_acc) + PW'(ls_acc);
         if (deq) rd_ptr <= rd_ptr + PW'(1);
         count <= count + CW'(perm_acc) + CW'(ls_acc) - CW'(deq);
         if ((perm_reg_write && !perm_acc) || (ls_reg_write && !ls_acc)) overflow <= 1'b1;
         if (load) begin
            rf_wr_en <= deq;
            if (deq) begin
               rf_wr_addr <= addr_q[rd_ptr];
               rf_wr_data <= data_q[rd_ptr];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (perm_acc) begin
         data_q[wr_ptr] <= perm_rt;
         addr_q[wr_ptr] <= perm_rt_addr;
      end
      if (ls_acc) begin
         data_q[ls_ptr] <= ls_rt;
         addr_q[ls_ptr] <= ls_rt_addr;
      end
   end

   assign stall = (32'(DEPTH) - 32'(count)) < 32'(STALL_MARGIN);

`ifdef ODD_WB_FWD_EN
   logic [PW-1:0] fwd_idx;

   // Scan oldest to youngest so the last match (youngest) wins.
   always_comb begin
      fwd_hit  = 1'b0;
      fwd_data = '0;
      fwd_idx  = '0;
      if (rf_wr_en && (rf_wr_addr == fwd_addr)) begin
         fwd_hit  = 1'b1;
         fwd_data = rf_wr_data;
      end
      for (int unsigned i = 0; i < DEPTH; i++) begin
         fwd_idx = rd_ptr + PW'(i);
         if ((CW'(i) < count) && (addr_q[fwd_idx] == fwd_addr)) begin
            fwd_hit  = 1'b1;
            fwd_data = data_q[fwd_idx];
         end
      end
   end
`else
   logic unused_fwd_addr;

   assign unused_fwd_addr = ^fwd_addr;
   assign fwd_hit         = 1'b0;
   assign fwd_data        = '0;
`endif

endmodule

// File: tb/tb_odd_wb_merge.sv
// Scoreboard bench for odd_wb_merge: stimulus pushes expected writes, a negedge monitor pops and compares.
module tb_odd_wb_merge;

   typedef struct packed {
      logic [6:0]   a;
      logic [127:0] d;
   } exp_t;

   logic         clk;
   logic         reset;
   logic [0:127] perm_rt;
   logic [0:6]   perm_rt_addr;
   logic         perm_reg_write;
   logic [0:127] ls_rt;
   logic [0:6]   ls_rt_addr;
   logic         ls_reg_write;
   logic         rf_ready;
   logic         rf_wr_en;
   logic [0:6]   rf_wr_addr;
   logic [0:127] rf_wr_data;
   logic         stall;
   logic         overflow;
   logic [0:6]   fwd_addr;
   logic         fwd_hit;
   logic [0:127] fwd_data;

   int unsigned n_vec = 0;
   int unsigned n_err = 0;
   exp_t        exp_q[$];

   odd_wb_merge #(.DEPTH(8), .STALL_MARGIN(5)) dut (
      .clk(clk), .reset(reset),
      .perm_rt(perm_rt), .perm_rt_addr(perm_rt_addr), .perm_reg_write(perm_reg_write),
      .ls_rt(ls_rt), .ls_rt_addr(ls_rt_addr), .ls_reg_write(ls_reg_write),
      .rf_ready(rf_ready), .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
      .stall(stall), .overflow(overflow),
      .fwd_addr(fwd_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, actual running, required finished");
      $fatal(1);
   end

   // Monitor: pop on every transfer, and require stable outputs after a stalled cycle.
   logic         held_v = 1'b0;
   logic [6:0]   held_a;
   logic [127:0] held_d;
   exp_t         mon_e;

   always @(negedge clk) begin
      if (!reset) begin
         held_v = 1'b0;
      end else begin
         if (held_v) begin
            n_vec++;
            if (!(rf_wr_en && rf_wr_addr == held_a && rf_wr_data == held_d)) begin
               n_err++;
               $display("FAIL hold: actual en=%0b addr=%0d data=%h, required en=1 addr=%0d data=%h",
                        rf_wr_en, rf_wr_addr, rf_wr_data, held_a, held_d);
            end
         end
         if (rf_wr_en && rf_ready) begin
            n_vec++;
            if (exp_q.size() == 0) begin
               n_err++;
               $display("FAIL write: actual addr=%0d data=%h, required no write", rf_wr_addr, rf_wr_data);
            end else begin
               mon_e = exp_q.pop_front();
               if (rf_wr_addr != mon_e.a || rf_wr_data != mon_e.d) begin
                  n_err++;
                  $display("FAIL write: actual addr=%0d data=%h, required addr=%0d data=%h",
                           rf_wr_addr, rf_wr_data, mon_e.a, mon_e.d);
               end
            end
         end
         held_v = rf_wr_en && !rf_ready;
         held_a = rf_wr_addr;
         held_d = rf_wr_data;
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: actual %h, required %h", name, act, req);
      end
   endtask

   // One cycle of input; pk/lk say whether the entry is expected to be kept.
   task automatic put(input logic pw, input logic [6:0] pa, input logic [127:0] pd, input logic pk,
                      input logic lw, input logic [6:0] la, input logic [127:0] ld, input logic lk);
      perm_reg_write = pw; perm_rt_addr = pa; perm_rt = pd;
      ls_reg_write   = lw; ls_rt_addr   = la; ls_rt   = ld;
      if (pw && pk) exp_q.push_back('{a: pa, d: pd});
      if (lw && lk) exp_q.push_back('{a: la, d: ld});
      tick();
      perm_reg_write = 1'b0;
      ls_reg_write   = 1'b0;
   endtask

   task automatic drain(input string name);
      rf_ready = 1'b1;
      for (int i = 0; i < 60 && (exp_q.size() != 0 || rf_wr_en); i++) tick();
      n_vec++;
      if (exp_q.size() != 0 || rf_wr_en) begin
         n_err++;
         $display("FAIL %s: actual %0d pending, required 0 pending", name, exp_q.size());
      end
   endtask

   initial begin
      reset = 1'b0; rf_ready = 1'b1; fwd_addr = '0;
      perm_rt = '0; perm_rt_addr = '0; perm_reg_write = 1'b0;
      ls_rt = '0; ls_rt_addr = '0; ls_reg_write = 1'b0;
      #12;
      chk("rst_en", 128'(rf_wr_en), 128'h0);
      chk("rst_addr", 128'(rf_wr_addr), 128'h0);
      chk("rst_data", rf_wr_data, 128'h0);
      chk("rst_stall", 128'(stall), 128'h0);
      chk("rst_ovf", 128'(overflow), 128'h0);
      chk("rst_fwd", 128'(fwd_hit), 128'h0);
      reset = 1'b1;
      tick();

      // Single perm write, plus an ignored cycle with garbage data
      put(1'b1, 7'd7, 128'h1, 1'b1, 1'b0, 7'd99, 128'hDEAD, 1'b0);
      chk("lat_e0", 128'(rf_wr_en), 128'h0);
      put(1'b0, 7'd55, 128'hBAD, 1'b0, 1'b0, 7'd56, 128'hBAD, 1'b0);
      chk("lat_e1_en", 128'(rf_wr_en), 128'h1);
      chk("lat_e1_addr", 128'(rf_wr_addr), 128'd7);
      chk("lat_e1_data", rf_wr_data, 128'h1);
      tick();
      chk("lat_e2_en", 128'(rf_wr_en), 128'h0);

      // Perm and ls together: perm first
      put(1'b1, 7'd3, 128'h33, 1'b1, 1'b1, 7'd4, 128'h44, 1'b1);
      tick();
      chk("ord_addr0", 128'(rf_wr_addr), 128'd3);
      tick();
      chk("ord_addr1", 128'(rf_wr_addr), 128'd4);
      chk("ord_data1", rf_wr_data, 128'h44);
      tick();
      chk("ord_idle", 128'(rf_wr_en), 128'h0);

      // Fill with rf_ready=0: stall from count>=4, ls dropped when one slot remains
      rf_ready = 1'b0;
      put(1'b1, 7'd16, 128'h100, 1'b1, 1'b1, 7'd17, 128'h101, 1'b1);
      chk("stall_c2", 128'(stall), 128'h0);
      put(1'b1, 7'd18, 128'h102, 1'b1, 1'b1, 7'd19, 128'h103, 1'b1);
      chk("stall_c3", 128'(stall), 128'h0);
      put(1'b1, 7'd20, 128'h104, 1'b1, 1'b1, 7'd21, 128'h105, 1'b1);
      chk("stall_c5", 128'(stall), 128'h1);
      put(1'b1, 7'd22, 128'h106, 1'b1, 1'b1, 7'd23, 128'h107, 1'b1);
      chk("stall_c7", 128'(stall), 128'h1);
      chk("ovf_pre", 128'(overflow), 128'h0);
      put(1'b1, 7'd24, 128'h108, 1'b1, 1'b1, 7'd25, 128'h109, 1'b0);
      chk("ovf_set", 128'(overflow), 128'h1);
      chk("full_head", 128'(rf_wr_addr), 128'd16);
      drain("drain_full");
      chk("ovf_sticky", 128'(overflow), 128'h1);
      chk("stall_empty", 128'(stall), 128'h0);

      // rf_ready toggling while valid
      rf_ready = 1'b0;
      put(1'b1, 7'd40, 128'h400, 1'b1, 1'b0, 7'd0, 128'h0, 1'b0);
      put(1'b1, 7'd41, 128'h401, 1'b1, 1'b0, 7'd0, 128'h0, 1'b0);
      put(1'b1, 7'd42, 128'h402, 1'b1, 1'b1, 7'd43, 128'h403, 1'b1);
      for (int i = 0; i < 8; i++) begin
         rf_ready = (i % 2 == 0);
         tick();
      end
      drain("drain_toggle");

      // Forwarding: addr 9 written 'hA then 'hB, plus addr 5
      rf_ready = 1'b0;
      put(1'b1, 7'd9, 128'hA, 1'b1, 1'b0, 7'd0, 128'h0, 1'b0);
      put(1'b1, 7'd9, 128'hB, 1'b1, 1'b0, 7'd0, 128'h0, 1'b0);
      put(1'b1, 7'd5, 128'hC, 1'b1, 1'b0, 7'd0, 128'h0, 1'b0);
      fwd_addr = 7'd9; #1;
`ifdef ODD_WB_FWD_EN
      chk("fwd9_hit", 128'(fwd_hit), 128'h1);
      chk("fwd9_data", fwd_data, 128'hB);
      fwd_addr = 7'd5; #1;
      chk("fwd5_data", fwd_data, 128'hC);
      fwd_addr = 7'd10; #1;
      chk("fwd10_hit", 128'(fwd_hit), 128'h0);
`else
      chk("fwd9_hit", 128'(fwd_hit), 128'h0);
      chk("fwd9_data", fwd_data, 128'h0);
`endif
      drain("drain_fwd");

      // Reset with entries queued and stall raised; overflow still set from the fill
      rf_ready = 1'b0;
      put(1'b1, 7'd50, 128'h500, 1'b0, 1'b1, 7'd51, 128'h501, 1'b0);
      put(1'b1, 7'd52, 128'h502, 1'b0, 1'b1, 7'd53, 128'h503, 1'b0);
      put(1'b1, 7'd54, 128'h504, 1'b0, 1'b1, 7'd55, 128'h505, 1'b0);
      chk("pre_rst_stall", 128'(stall), 128'h1);
      #2;
      reset = 1'b0;
      #1;
      chk("mid_rst_en", 128'(rf_wr_en), 128'h0);
      chk("mid_rst_stall", 128'(stall), 128'h0);
      chk("mid_rst_ovf", 128'(overflow), 128'h0);
      @(negedge clk);
      #2;
      reset = 1'b1;
      rf_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("post_rst_empty", 128'(rf_wr_en), 128'h0);
      end
      chk("scoreboard_empty", 128'(exp_q.size()), 128'h0);

      tick();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
